// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RISC-V core.
//
// Holds the 64-bit program counter. It drives the address of a combinational,
// byte-addressed instruction memory, which returns a big-endian 32-bit word in
// the same cycle. The returned word and its PC are captured in the IF/ID
// pipeline register.
//
// The stage also handles:
//   - hazard stall
//   - branch/jump redirect
//   - end-of-program halt, detected as an all-zero word
//   - fetch fault, for a misaligned or out-of-range PC
//
// Ports:
//   clk             core clock, rising edge
//   reset           asynchronous active-high reset
//   stall           hold PC and IF/ID
//   redirect        taken branch/jump; load redirect_target, squash fetch
//   redirect_target next PC when redirect=1
//   imem_instr      word returned by instruction memory for imem_addr
//   imem_addr       current PC (register copy, no combinational input path)
//   if_id_pc        PC of the latched instruction
//   if_id_instr     latched instruction (NOP_INSTR when invalid after squash/reset)
//   if_id_valid     IF/ID holds a real instruction
//   halted          sticky end-of-program flag
//   fault           sticky fetch-fault flag
//   fault_pc        PC that caused the fault
//   fetch_count     saturating count of instructions latched valid

module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_SIZE  = 4095,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  input  logic [31:0] imem_instr,
  output logic [63:0] imem_addr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault,
  output logic [63:0] fault_pc,
  output logic [31:0] fetch_count
);

  // Highest PC whose full 4-byte word lies inside the memory.
  localparam logic [63:0] PcMax = 64'(MEM_SIZE) - 64'd4;

  typedef enum logic [1:0] {
    StRun,
    StHalt,
    StFault
  } state_e;

  state_e      state;
  logic [63:0] pc;
  logic        pc_bad;

  assign imem_addr = pc;
  assign halted    = (state == StHalt);
  assign fault     = (state == StFault);
  assign pc_bad    = (pc[1:0] != 2'b00) || (pc > PcMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StRun;
      pc          <= RESET_PC;
      if_id_pc    <= 64'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fault_pc    <= 64'h0;
      fetch_count <= 32'h0;
    end else begin
      unique case (state)
        StRun: begin
          if (redirect) begin
            // Squash the in-flight fetch; the new PC is checked next cycle.
            pc          <= redirect_target;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end else if (stall) begin
            // Hold everything; a pending halt/fault waits for stall to drop.
          end else if (pc_bad) begin
            // Checked before halt so an out-of-range PC never reports halted.
            state       <= StFault;
            fault_pc    <= pc;
            if_id_valid <= 1'b0;
          end else if (imem_instr == 32'h0) begin
            state       <= StHalt;
            if_id_valid <= 1'b0;
          end else begin
            if_id_instr <= imem_instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= pc + 64'd4;
            if (fetch_count != 32'hFFFF_FFFF) begin
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        StHalt, StFault: begin
          // Terminal: only reset leaves these states.
        end
        default: begin
          state <= StFault;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. A byte-array model of the
// instruction memory answers imem_addr combinationally, big-endian.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [31:0] imem_instr;
  logic [63:0] imem_addr;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [0:4095];

  fetch_stage #(
    .RESET_PC (64'h0),
    .MEM_SIZE (4095),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_instr     (imem_instr),
    .imem_addr      (imem_addr),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fetch_word(input logic [63:0] a);
    int i;
    if (a < 64'd4093) begin
      i = int'(a[11:0]);
      return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    end
    return 32'h0;
  endfunction

  always_comb imem_instr = fetch_word(imem_addr);

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]   = w[31:24];
    mem[a+1] = w[23:16];
    mem[a+2] = w[15:8];
    mem[a+3] = w[7:0];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " addr"},  imem_addr, 64'h0);
    check({tag, " pc"},    if_id_pc, 64'h0);
    check({tag, " instr"}, 64'(if_id_instr), 64'h13);
    check({tag, " valid"}, 64'(if_id_valid), 64'h0);
    check({tag, " halt"},  64'(halted), 64'h0);
    check({tag, " fault"}, 64'(fault), 64'h0);
    check({tag, " fpc"},   fault_pc, 64'h0);
    check({tag, " cnt"},   64'(fetch_count), 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 64'h0;
    clear_mem();
    put_word(0, 32'h00500093);
    put_word(4, 32'h00A00113);
    put_word(8, 32'h00000000);
    put_word(64, 32'h00100093);

    // Reset values
    #2;
    check_reset_values("rst");
    #10 reset = 1'b0;  // t=12, between edges

    // Straight-line fetch then halt on zero word
    step();
    check("f0 instr", 64'(if_id_instr), 64'h00500093);
    check("f0 pc",    if_id_pc, 64'h0);
    check("f0 valid", 64'(if_id_valid), 64'h1);
    check("f0 addr",  imem_addr, 64'h4);
    step();
    check("f1 instr", 64'(if_id_instr), 64'h00A00113);
    check("f1 pc",    if_id_pc, 64'h4);
    check("f1 cnt",   64'(fetch_count), 64'h2);
    step();
    check("h halt",  64'(halted), 64'h1);
    check("h valid", 64'(if_id_valid), 64'h0);
    check("h cnt",   64'(fetch_count), 64'h2);
    check("h addr",  imem_addr, 64'h8);
    redirect = 1'b1;
    redirect_target = 64'h40;
    step();
    check("h2 addr", imem_addr, 64'h8);
    check("h2 halt", 64'(halted), 64'h1);
    redirect = 1'b0;

    // Asynchronous reset between edges while halted
    #3 reset = 1'b1;
    #1;
    check_reset_values("arst");
    #2 reset = 1'b0;
    step();
    check("rs instr", 64'(if_id_instr), 64'h00500093);
    check("rs valid", 64'(if_id_valid), 64'h1);
    check("rs cnt",   64'(fetch_count), 64'h1);

    // Stall for three cycles after the first fetch
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("st addr",  imem_addr, 64'h4);
      check("st instr", 64'(if_id_instr), 64'h00500093);
      check("st valid", 64'(if_id_valid), 64'h1);
      check("st cnt",   64'(fetch_count), 64'h1);
    end
    stall = 1'b0;
    step();
    check("sr instr", 64'(if_id_instr), 64'h00A00113);
    check("sr pc",    if_id_pc, 64'h4);
    check("sr cnt",   64'(fetch_count), 64'h2);

    // Redirect together with stall; pc=8 would otherwise halt
    redirect = 1'b1;
    redirect_target = 64'h40;
    stall = 1'b1;
    step();
    check("rd addr",  imem_addr, 64'h40);
    check("rd valid", 64'(if_id_valid), 64'h0);
    check("rd instr", 64'(if_id_instr), 64'h13);
    check("rd cnt",   64'(fetch_count), 64'h2);
    check("rd halt",  64'(halted), 64'h0);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    check("rt instr", 64'(if_id_instr), 64'h00100093);
    check("rt pc",    if_id_pc, 64'h40);
    check("rt valid", 64'(if_id_valid), 64'h1);
    check("rt cnt",   64'(fetch_count), 64'h3);

    // Misaligned redirect target faults one cycle later
    redirect = 1'b1;
    redirect_target = 64'h42;
    step();
    check("ma addr",  imem_addr, 64'h42);
    check("ma fault", 64'(fault), 64'h0);
    redirect = 1'b0;
    step();
    check("mf fault", 64'(fault), 64'h1);
    check("mf fpc",   fault_pc, 64'h42);
    check("mf valid", 64'(if_id_valid), 64'h0);
    check("mf halt",  64'(halted), 64'h0);
    redirect = 1'b1;
    redirect_target = 64'h100;
    stall = 1'b1;
    step();
    redirect = 1'b0;
    step();
    stall = 1'b0;
    step();
    check("mh addr",  imem_addr, 64'h42);
    check("mh fault", 64'(fault), 64'h1);
    check("mh cnt",   64'(fetch_count), 64'h3);

    // Out-of-range: fetch 4080..4088, then pc=4092 > 4091 faults (not halts)
    reset = 1'b1;
    put_word(4080, 32'h00100093);
    put_word(4084, 32'h00200093);
    put_word(4088, 32'h00300093);
    #2 reset = 1'b0;
    redirect = 1'b1;
    redirect_target = 64'd4080;
    step();
    redirect = 1'b0;
    check("or addr", imem_addr, 64'd4080);
    step();
    step();
    step();
    check("or last",  64'(if_id_instr), 64'h00300093);
    check("or lpc",   if_id_pc, 64'd4088);
    check("or cnt",   64'(fetch_count), 64'h3);
    check("or addr2", imem_addr, 64'd4092);
    step();
    check("of fault", 64'(fault), 64'h1);
    check("of fpc",   fault_pc, 64'd4092);
    check("of halt",  64'(halted), 64'h0);
    check("of valid", 64'(if_id_valid), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
